fp16_div_sequencer: RTL

Sequencing controller for the half-precision (FP16) divider. It latches the divisible/divider operands on a start handshake and screens special operands. For normal operands it computes sign and biased exponent, then drives an iterative restoring mantissa division, one quotient bit per clock. It normalises, checks exponent range and returns a registered FP16 result with status flags and a one-cycle done pulse. It sits between the ALU issue logic and the divider datapath, and only one division is in flight at a time.

---
 rtl/fp16_div_pkg.sv | 52 +++++
 rtl/fp16_mant_div_iter.sv | 69 ++++++
 rtl/fp16_div_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fp16_div_pkg.sv
// ---------------------------------------------------------------------------
// fp16_div_pkg
// Shared definitions for the FP16 divider sequencer and its mantissa
// iteration unit: sequencer state encoding, FP16 field layout, exponent
// bias, quotient width, special-value constants and operand classification.
// ---------------------------------------------------------------------------
package fp16_div_pkg;

  // FP16 field layout: {sign, exp[14:10], mant[9:0]}
  localparam int SIGN_POS = 15;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;
  localparam int EXP_LSB  = MANT_W;
  localparam int EXP_MSB  = MANT_W + EXP_W - 1;

  localparam int EXP_BIAS = 15;
  // 11 significant quotient bits plus one normalisation bit
  localparam int Q_BITS   = 12;

  localparam logic [15:0]      QNAN    = 16'h7E00;
  localparam logic [EXP_W-1:0] INF_EXP = 5'h1F;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ITER,
    NORM,
    DONE
  } state_t;

  function automatic logic [EXP_W-1:0] exp_of(input logic [15:0] x);
    return x[EXP_MSB:EXP_LSB];
  endfunction

  function automatic logic [MANT_W-1:0] mant_of(input logic [15:0] x);
    return x[MANT_W-1:0];
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (exp_of(x) == INF_EXP) && (mant_of(x) != '0);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (exp_of(x) == INF_EXP) && (mant_of(x) == '0);
  endfunction

  // Subnormals are flushed: any zero exponent counts as zero.
  function automatic logic is_zero(input logic [15:0] x);
    return exp_of(x) == '0;
  endfunction

endpackage

// File: rtl/fp16_mant_div_iter.sv
// ---------------------------------------------------------------------------
// fp16_mant_div_iter
// Restoring mantissa divider producing one quotient bit per step.
//
// Ports:
//   clk   in   system clock, rising edge
//   res   in   asynchronous active-low reset
//   load  in   capture ma as the remainder, mb as the divisor, clear q/count
//   step  in   perform one restoring iteration
//   ma    in   dividend significand {1, mant}
//   mb    in   divisor significand {1, mant}
//   q     out  quotient bits, MSB first (q[Q_BITS-1] is the integer bit)
//   last  out  high while the step in progress is the final one
// ---------------------------------------------------------------------------
module fp16_mant_div_iter #(
  parameter int Q_BITS = fp16_div_pkg::Q_BITS
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          load,
  input  logic                          step,
  input  logic [fp16_div_pkg::MANT_W:0] ma,
  input  logic [fp16_div_pkg::MANT_W:0] mb,
  output logic [Q_BITS-1:0]             q,
  output logic                          last
);
  import fp16_div_pkg::*;

  localparam int SIG_W = MANT_W + 1;
  // The remainder stays below 2*mb, so one bit above the significand is enough.
  localparam int R_W   = SIG_W + 1;
  localparam int CNT_W = $clog2(Q_BITS);

  logic [R_W-1:0]   r;
  logic [R_W-1:0]   r_next;
  logic [R_W-1:0]   diff;
  logic [SIG_W-1:0] mb_q;
  logic [CNT_W-1:0] count;
  logic             qbit;

  // One restoring step: subtract when the remainder covers the divisor,
  // then shift the remainder left to line up the next quotient bit.
  always_comb begin
    diff   = r - {1'b0, mb_q};
    qbit   = (r >= {1'b0, mb_q});
    r_next = qbit ? (diff << 1) : (r << 1);
  end

  assign last = (count == CNT_W'(Q_BITS - 1));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r     <= '0;
      mb_q  <= '0;
      q     <= '0;
      count <= '0;
    end else if (load) begin
      r     <= {1'b0, ma};
      mb_q  <= mb;
      q     <= '0;
      count <= '0;
    end else if (step) begin
      r     <= r_next;
      q     <= {q[Q_BITS-2:0], qbit};
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fp16_div_sequencer.sv
// ---------------------------------------------------------------------------
// fp16_div_sequencer
// Sequencing controller for the FP16 divider. Latches operands on start,
// screens special operands, runs a restoring mantissa division (one bit per
// clock), normalises, range-checks the exponent and returns a registered
// FP16 quotient with status flags and a one-cycle done pulse.
//
// Ports:
//   clk          in   system clock, rising edge
//   res          in   asynchronous active-low reset
//   start        in   request a division (sampled only in IDLE)
//   divisible    in   FP16 dividend
//   divider      in   FP16 divisor
//   busy         out  high whenever the sequencer is not idle
//   done         out  one-cycle pulse, result and flags valid
//   result       out  FP16 quotient, held until the next accepted start
//   div_by_zero  out  nonzero / zero
//   invalid      out  NaN operand, 0/0 or inf/inf
//   overflow     out  result exponent >= 31
//   underflow    out  result exponent <= 0, flushed to zero
// ---------------------------------------------------------------------------
module fp16_div_sequencer #(
  parameter int EXP_BIAS = fp16_div_pkg::EXP_BIAS,
  parameter int Q_BITS   = fp16_div_pkg::Q_BITS
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [15:0] divisible,
  input  logic [15:0] divider,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        div_by_zero,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow
);
  import fp16_div_pkg::*;

  state_t state;
  state_t state_n;

  logic [15:0]       a_q;
  logic [15:0]       b_q;
  logic              sign_q;
  logic signed [6:0] exp_q;

  logic              load;
  logic              step;
  logic [Q_BITS-1:0] q;
  logic              iter_last;

  logic              sign_c;
  logic [6:0]        exp_c;
  logic              special;
  logic [15:0]       special_result;
  logic              special_invalid;
  logic              special_dbz;

  logic signed [6:0] exp_adj;
  logic [MANT_W-1:0] mant_n;
  logic [15:0]       norm_result;
  logic              norm_ovf;
  logic              norm_unf;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  fp16_mant_div_iter #(
    .Q_BITS (Q_BITS)
  ) u_iter (
    .clk  (clk),
    .res  (res),
    .load (load),
    .step (step),
    .ma   ({1'b1, mant_of(a_q)}),
    .mb   ({1'b1, mant_of(b_q)}),
    .q    (q),
    .last (iter_last)
  );

  // Operand screening on the latched operands, in priority order.
  // Also forms the biased exponent difference for the normal path.
  always_comb begin
    sign_c          = a_q[SIGN_POS] ^ b_q[SIGN_POS];
    exp_c           = {2'b00, exp_of(a_q)} - {2'b00, exp_of(b_q)} + 7'(EXP_BIAS);
    special         = 1'b1;
    special_result  = '0;
    special_invalid = 1'b0;
    special_dbz     = 1'b0;
    if (is_nan(a_q) || is_nan(b_q) ||
        (is_zero(a_q) && is_zero(b_q)) ||
        (is_inf(a_q) && is_inf(b_q))) begin
      special_result  = QNAN;
      special_invalid = 1'b1;
    end else if (is_zero(b_q)) begin
      special_result = {sign_c, INF_EXP, {MANT_W{1'b0}}};
      special_dbz    = 1'b1;
    end else if (is_zero(a_q) || is_inf(b_q)) begin
      special_result = {sign_c, 15'h0000};
    end else if (is_inf(a_q)) begin
      special_result = {sign_c, INF_EXP, {MANT_W{1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Normalisation: the quotient of two significands lies in (0.5, 2), so at
  // most a single left shift is needed. Extra quotient bits are truncated.
  always_comb begin
    if (q[Q_BITS-1]) begin
      exp_adj = exp_q;
      mant_n  = q[Q_BITS-2 -: MANT_W];
    end else begin
      exp_adj = exp_q - 7'sd1;
      mant_n  = q[Q_BITS-3 -: MANT_W];
    end
    norm_ovf    = (exp_adj >= 7'sd31);
    norm_unf    = (exp_adj <= 7'sd0);
    norm_result = {sign_q, exp_adj[EXP_W-1:0], mant_n};
    if (norm_ovf) begin
      norm_result = {sign_q, INF_EXP, {MANT_W{1'b0}}};
    end else if (norm_unf) begin
      norm_result = {sign_q, 15'h0000};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and iteration control.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = CHECK;
      end
      CHECK: begin
        if (special) begin
          state_n = DONE;
        end else begin
          state_n = ITER;
          load    = 1'b1;
        end
      end
      ITER: begin
        step = 1'b1;
        if (iter_last) state_n = NORM;
      end
      NORM:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture and registered result/flags. Result and flags only
  // change on an accepted start, a special-case resolve, or normalisation.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q         <= divisible;
            b_q         <= divider;
            result      <= '0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
          end
        end
        CHECK: begin
          sign_q <= sign_c;
          if (special) begin
            result      <= special_result;
            invalid     <= special_invalid;
            div_by_zero <= special_dbz;
          end else begin
            exp_q <= exp_c;
          end
        end
        NORM: begin
          result    <= norm_result;
          overflow  <= norm_ovf;
          underflow <= norm_unf;
        end
        default: ;
      endcase
    end
  end

endmodule
